// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern-detection controller.
// Parallel words arrive over valid/ready and are shifted MSB-first into a
// history register. The history is compared against a runtime pattern of
// 1..PAT_W bits. Matches are counted (saturating), and a sticky irq fires
// when the count reaches a programmable threshold.
module seq_det_ctrl #(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 8,
  parameter int CNT_W  = 8,
  localparam int LEN_W = $clog2(PAT_W) + 1,
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_overlap,
  input  logic [CNT_W-1:0]  cfg_thresh,
  input  logic              start,
  input  logic              stop,
  input  logic              irq_clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              sin_out,
  output logic              match,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              irq,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WAIT, SHIFT} state_t;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  sreg;
  logic [PAT_W-1:0]   hist;
  logic [LEN_W-1:0]   fill;
  logic [IDX_W-1:0]   bit_idx;
  logic [PAT_W-1:0]   pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [CNT_W-1:0]   thr_q;

  logic               handshake;
  logic               last_bit;
  logic               shift_en;
  logic               start_run;
  logic               load;
  logic [PAT_W-1:0]   hist_nxt;
  logic [LEN_W-1:0]   fill_nxt;
  logic [PAT_W-1:0]   len_mask;
  logic               match_nxt;
  logic               cnt_max;
  logic [CNT_W-1:0]   cnt_inc;

  // Length 0 behaves as 1; anything longer than the history is clamped.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l == '0)
      return LEN_W'(1);
    else if (l > LEN_W'(PAT_W))
      return LEN_W'(PAT_W);
    else
      return l;
  endfunction

  // Fill level saturates at the history width.
  function automatic logic [LEN_W-1:0] sat_fill(input logic [LEN_W-1:0] f);
    if (f >= LEN_W'(PAT_W))
      return LEN_W'(PAT_W);
    else
      return f + LEN_W'(1);
  endfunction

  assign handshake = in_valid & in_ready;
  assign last_bit  = (bit_idx == IDX_W'(DATA_W - 1));
  // stop discards any bit that would otherwise be shifted this edge
  assign shift_en  = (state == SHIFT) & ~stop;
  assign start_run = (state == IDLE) & start & ~stop;
  assign load      = (state != IDLE) & handshake & ~stop;
  assign hist_nxt  = {hist[PAT_W-2:0], sreg[DATA_W-1]};
  assign fill_nxt  = sat_fill(fill);
  assign cnt_max   = &match_cnt;
  assign cnt_inc   = match_cnt + CNT_W'(1);

  // Mask selecting the low len_q bits of history and pattern.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < PAT_W; i++)
      len_mask[i] = (LEN_W'(i) < len_q);
  end

  // Match is judged on the history as it will look after this edge's shift.
  assign match_nxt = shift_en & (fill_nxt >= len_q) &
                     (((hist_nxt ^ pat_q) & len_mask) == '0);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic; stop always takes priority.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start && !stop) state_nxt = WAIT;
      WAIT:  if (stop) state_nxt = IDLE;
             else if (handshake) state_nxt = SHIFT;
      SHIFT: if (stop) state_nxt = IDLE;
             else if (last_bit && !handshake) state_nxt = WAIT;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore-style outputs; in_ready opens on the last bit for gap-free streaming.
  always_comb begin
    in_ready = 1'b0;
    busy     = (state != IDLE);
    case (state)
      WAIT:    in_ready = 1'b1;
      SHIFT:   in_ready = last_bit;
      default: in_ready = 1'b0;
    endcase
  end

  // Configuration registers, writable only while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q <= '0;
      len_q <= '0;
      ovl_q <= 1'b0;
      thr_q <= '0;
    end else if (state == IDLE && cfg_we) begin
      pat_q <= cfg_pattern;
      len_q <= clamp_len(cfg_len);
      ovl_q <= cfg_overlap;
      thr_q <= cfg_thresh;
    end
  end

  // Serialiser: word load, MSB-first shift and bit position.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg    <= '0;
      bit_idx <= '0;
      sin_out <= 1'b0;
    end else begin
      if (load) begin
        sreg    <= in_data;
        bit_idx <= '0;
      end else if (shift_en) begin
        sreg    <= sreg << 1;
        bit_idx <= bit_idx + IDX_W'(1);
      end
      if (shift_en)
        sin_out <= sreg[DATA_W-1];
    end
  end

  // Detector history, fill level and registered match pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else begin
      match <= match_nxt;
      if (start_run) begin
        hist <= '0;
        fill <= '0;
      end else if (shift_en) begin
        hist <= hist_nxt;
        // Non-overlapping mode must see a fresh len bits before the next hit.
        fill <= (match_nxt && !ovl_q) ? '0 : fill_nxt;
      end
    end
  end

  // Saturating match counter and sticky threshold interrupt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_cnt <= '0;
      irq       <= 1'b0;
    end else if (start_run) begin
      match_cnt <= '0;
      irq       <= 1'b0;
    end else begin
      if (match_nxt && !cnt_max)
        match_cnt <= cnt_inc;
      if (match_nxt && !cnt_max && thr_q != '0 && cnt_inc == thr_q)
        irq <= 1'b1;
      else if (irq_clr)
        irq <= 1'b0;
    end
  end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Programmable serial pattern-detection controller. It accepts parallel words over a valid/ready handshake and serialises them MSB-first into an internal shift-history detector. The detector matches a runtime-configured pattern of 1..PAT_W bits, in overlapping or non-overlapping mode. The block counts matches and raises a sticky interrupt at a programmable threshold; it is the sequencing and configuration layer around the team's serial sequence detector.

Parameters:
DATA_W, 8, width of each parallel input word (bits shifted per word)
PAT_W, 8, maximum pattern length and history register width
CNT_W, 8, width of match counter and threshold

Ports:
clk  in  1  single clock, rising-edge
rst  in  1  asynchronous, active-low reset (0 = reset)
cfg_we  in  1  config write strobe; honoured only in IDLE
cfg_pattern  in  PAT_W  pattern, LSB = most recent bit
cfg_len  in  $clog2(PAT_W)+1  pattern length; 0 treated as 1, >PAT_W clamped to PAT_W
cfg_overlap  in  1  1 = overlapping matches allowed
cfg_thresh  in  CNT_W  irq threshold; 0 = irq disabled
start  in  1  arm detector (IDLE only)
stop  in  1  abort to IDLE from any state
irq_clr  in  1  clear irq
in_valid  in  1  input word valid
in_data  in  DATA_W  input word
in_ready  out  1  controller can accept a word
sin_out  out  1  registered copy of the bit currently being detected
match  out  1  one-cycle pulse per detected match
match_cnt  out  CNT_W  matches since last start, saturating
irq  out  1  sticky threshold interrupt
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE; sreg, hist, fill, bit_idx, config regs, sin_out, match, match_cnt, irq = 0; in_ready=0; busy=0.
- Config: on cfg_we in IDLE, latch pattern/len(after clamp)/overlap/thresh; cfg_we outside IDLE ignored.
- States: IDLE, WAIT, SHIFT.
- IDLE: in_ready=0. start (and not stop) -> WAIT; at the same edge clear match_cnt, irq, hist, fill.
- WAIT: in_ready=1. Handshake (in_valid & in_ready) -> load sreg=in_data, bit_idx=0, go SHIFT.
- SHIFT: one bit per clock. Each edge: hist <= {hist[PAT_W-2:0], sreg[DATA_W-1]}; sreg <<= 1; sin_out <= shifted bit; fill <= min(fill+1, PAT_W); bit_idx++.
- in_ready=1 in SHIFT only when bit_idx==DATA_W-1. A handshake there reloads sreg at the edge that shifts the last bit, giving gap-free streaming. Without a handshake -> WAIT after the last bit.
- Match: evaluated on the post-shift history. match <= (fill_next >= len) & (hist_next[len-1:0] == pattern[len-1:0]). match is registered, so it is high in the same cycle sin_out shows the completing bit.
- Non-overlap: on a match, fill is forced to 0 at that edge (hist value kept, but ignored until refilled). Overlap: fill is unaffected.
- Counter: match_cnt increments on each match and saturates at all-ones.
- irq: set when match_cnt increments to a value equal to cfg_thresh (thresh!=0). Held until irq_clr or start. If set and irq_clr coincide, set wins.
- stop: from WAIT/SHIFT -> IDLE at the next edge. The remaining bits are discarded, and match is not asserted for them. match_cnt and irq are preserved. stop wins over a simultaneous start or handshake.
- start while busy is ignored. in_data is ignored without a handshake.
- Detection history persists across word boundaries within one run, so patterns may span words.

Test Plan:
- Reset mid-SHIFT (drive rst=0 asynchronously between edges) -> all outputs 0 immediately, busy=0; after release the block stays IDLE until start.
- pattern=4'b1011, len=4, overlap=0, word 0x2D (00101101) -> sin_out 0,0,1,0,1,1,0,1; exactly one match pulse, on the 6th SHIFT cycle; match_cnt=1.
- pattern=3'b101, len=3, word 0xAA: overlap=1 -> matches on bits 3,5,7, match_cnt=3; overlap=0 -> matches on bits 3,7, match_cnt=2.
- Same overlap run with thresh=2 -> irq rises with the 2nd match and stays high after the 3rd. irq_clr then gives irq=0, and irq stays 0 because no re-trigger occurs at count 3.
- Back-to-back: in_valid held high with words 0x01 then 0x80, pattern=2'b11, len=2 -> 16 consecutive SHIFT cycles with no WAIT gap; one match on bit 9 (spans the word boundary).
- stop asserted at bit 4 of a word containing a later match -> IDLE on the next edge with no further match; match_cnt unchanged. start issued together with stop -> still IDLE. A cfg_we issued in SHIFT is ignored.
